// File: rtl/psk_tx_frame_sched_if.sv
// Byte-stream bundle around the PSK frame scheduler: two requester streams in,
// one framed stream out to the modulator.
interface psk_tx_frame_sched_if;
    logic       s0_req;
    logic [7:0] s0_len;
    logic [7:0] s0_tdata;
    logic       s0_tvalid;
    logic       s0_tlast;
    logic       s0_tready;
    logic       s0_grant;

    logic       s1_req;
    logic [7:0] s1_len;
    logic [7:0] s1_tdata;
    logic       s1_tvalid;
    logic       s1_tlast;
    logic       s1_tready;
    logic       s1_grant;

    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;
    logic       m_tuser;

    // Scheduler side
    modport master (
        input  s0_req, s0_len, s0_tdata, s0_tvalid, s0_tlast,
        output s0_tready, s0_grant,
        input  s1_req, s1_len, s1_tdata, s1_tvalid, s1_tlast,
        output s1_tready, s1_grant,
        output m_tdata, m_tvalid, m_tlast, m_tuser,
        input  m_tready
    );

    // Requesters and modulator side
    modport slave (
        output s0_req, s0_len, s0_tdata, s0_tvalid, s0_tlast,
        input  s0_tready, s0_grant,
        output s1_req, s1_len, s1_tdata, s1_tvalid, s1_tlast,
        input  s1_tready, s1_grant,
        input  m_tdata, m_tvalid, m_tlast, m_tuser,
        output m_tready
    );
endinterface

// File: rtl/psk_tx_frame_sched.sv
// Frame scheduler for the PSK modulator byte stream: round-robin over two
// requesters, wraps each packet as preamble, sync word, length byte, payload.
module psk_tx_frame_sched #(
    parameter int unsigned PREAMBLE_LEN  = 4,
    parameter logic [7:0]  PREAMBLE_BYTE = 8'hAA,
    parameter logic [15:0] SYNC_WORD     = 16'h7E81,
    parameter int unsigned GAP_CYCLES    = 16
) (
    input  logic                 clk_16d384M,
    input  logic                 rst_16d384M,
    input  logic                 tx_en,
    psk_tx_frame_sched_if.master bus,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic                 len_err
);
    typedef enum logic [2:0] {
        IDLE, PRE, SYNC_H, SYNC_L, LEN, PAYLOAD, DRAIN, GAP
    } state_t;

    localparam logic [7:0] PRE_LAST  = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
    localparam state_t     END_STATE = (GAP_CYCLES == 0) ? IDLE : GAP;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic        src_q, src_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic        drained_q, drained_d;
    logic        ov_q, ov_d;
    logic [7:0]  od_q, od_d;
    logic        ol_q, ol_d;
    logic        ou_q, ou_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        err_q, err_d;
    logic        g0_q, g0_d;
    logic        g1_q, g1_d;

    logic        load_en;
    logic        last_pend;
    logic        src_tvalid;
    logic        src_tlast;
    logic [7:0]  src_tdata;
    logic [7:0]  cnt_inc;
    logic        at_len;
    logic        pick;
    logic        src_ready;
    logic        drain_last;

    always_comb begin
        load_en    = !ov_q || bus.m_tready;
        last_pend  = ov_q && ol_q;
        src_tvalid = src_q ? bus.s1_tvalid : bus.s0_tvalid;
        src_tlast  = src_q ? bus.s1_tlast  : bus.s0_tlast;
        src_tdata  = src_q ? bus.s1_tdata  : bus.s0_tdata;
        cnt_inc    = cnt_q + 8'd1;
        at_len     = (cnt_inc == len_q);
        // ptr_q names the side that wins a tie
        pick       = (bus.s0_req && bus.s1_req) ? ptr_q : bus.s1_req;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        src_d      = src_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        gap_d      = 8'd0;
        drained_d  = drained_q;
        ov_d       = ov_q && !bus.m_tready;
        od_d       = od_q;
        ol_d       = ol_q;
        ou_d       = ou_q;
        fcnt_d     = fcnt_q;
        err_d      = 1'b0;
        g0_d       = 1'b0;
        g1_d       = 1'b0;
        src_ready  = 1'b0;
        drain_last = 1'b0;

        if (last_pend && bus.m_tready) begin
            fcnt_d = fcnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (tx_en && (bus.s0_req || bus.s1_req)) begin
                    state_d   = PRE;
                    src_d     = pick;
                    ptr_d     = !pick;
                    len_d     = pick ? bus.s1_len : bus.s0_len;
                    g0_d      = !pick;
                    g1_d      = pick;
                    cnt_d     = 8'd0;
                    drained_d = 1'b0;
                end
            end
            PRE: begin
                if (load_en) begin
                    ov_d = 1'b1;
                    od_d = PREAMBLE_BYTE;
                    ol_d = 1'b0;
                    ou_d = 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        cnt_d   = 8'd0;
                        state_d = SYNC_H;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            SYNC_H: begin
                if (load_en) begin
                    ov_d    = 1'b1;
                    od_d    = SYNC_WORD[15:8];
                    ol_d    = 1'b0;
                    ou_d    = 1'b1;
                    state_d = SYNC_L;
                end
            end
            SYNC_L: begin
                if (load_en) begin
                    ov_d    = 1'b1;
                    od_d    = SYNC_WORD[7:0];
                    ol_d    = 1'b0;
                    ou_d    = 1'b1;
                    state_d = LEN;
                end
            end
            LEN: begin
                // A zero-length frame ends on this byte; hold here until it is taken
                if (last_pend) begin
                    if (bus.m_tready) begin
                        state_d = END_STATE;
                    end
                end else if (load_en) begin
                    ov_d = 1'b1;
                    od_d = len_q;
                    ol_d = (len_q == 8'd0);
                    ou_d = 1'b1;
                    if (len_q != 8'd0) begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (last_pend) begin
                    if (bus.m_tready) begin
                        state_d = END_STATE;
                    end
                end else begin
                    src_ready = load_en;
                    if (load_en && src_tvalid) begin
                        ov_d  = 1'b1;
                        od_d  = src_tdata;
                        ol_d  = src_tlast || at_len;
                        ou_d  = 1'b0;
                        cnt_d = cnt_inc;
                        err_d = (src_tlast != at_len);
                        if (at_len && !src_tlast) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                // Discard the source overrun while the truncated last byte drains out
                src_ready  = !drained_q;
                drain_last = src_ready && src_tvalid && src_tlast;
                if (drain_last) begin
                    drained_d = 1'b1;
                end
                if ((drained_q || drain_last) && (!last_pend || bus.m_tready)) begin
                    state_d = END_STATE;
                end
            end
            GAP: begin
                gap_d = gap_q + 8'd1;
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_16d384M) begin
        if (rst_16d384M) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            src_q     <= 1'b0;
            len_q     <= 8'd0;
            cnt_q     <= 8'd0;
            gap_q     <= 8'd0;
            drained_q <= 1'b0;
            ov_q      <= 1'b0;
            od_q      <= 8'd0;
            ol_q      <= 1'b0;
            ou_q      <= 1'b0;
            fcnt_q    <= 16'd0;
            err_q     <= 1'b0;
            g0_q      <= 1'b0;
            g1_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            src_q     <= src_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            drained_q <= drained_d;
            ov_q      <= ov_d;
            od_q      <= od_d;
            ol_q      <= ol_d;
            ou_q      <= ou_d;
            fcnt_q    <= fcnt_d;
            err_q     <= err_d;
            g0_q      <= g0_d;
            g1_q      <= g1_d;
        end
    end

    assign bus.m_tvalid  = ov_q;
    assign bus.m_tdata   = od_q;
    assign bus.m_tlast   = ol_q;
    assign bus.m_tuser   = ou_q;
    assign bus.s0_tready = src_ready && !src_q;
    assign bus.s1_tready = src_ready && src_q;
    assign bus.s0_grant  = g0_q;
    assign bus.s1_grant  = g1_q;
    assign busy          = (state_q != IDLE);
    assign frame_cnt     = fcnt_q;
    assign len_err       = err_q;

endmodule
